// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage of the RV32I pipeline.
// Runs one Wishbone B4 classic single-beat data-bus cycle per memory
// instruction and holds the pipeline until the access finishes. The result
// is either a one-cycle completion pulse carrying formatted load data or a
// one-cycle exception pulse carrying the mcause code and faulting address.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    output logic        mem_ack_o,
    output logic [31:0] mem_dat_o,
    output logic [4:0]  mem_rd_o,
    output logic        excp_o,
    output logic [3:0]  excp_code_o,
    output logic [31:0] excp_addr_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2,
        EXC  = 2'd3
    } state_t;

    // Internal access size: funct3 encodings 011/110/111 fall through to word.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // The last BUS cycle (counter value) before the access is declared faulty.
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    // mcause codes.
    localparam logic [3:0] CODE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CODE_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] CODE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CODE_STORE_FAULT    = 4'd7;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [4:0]  rd_q;
    logic        store_q;

    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [3:0]  sel_q;
    logic [31:0] wdat_q;
    logic        memAck_q;
    logic [31:0] memDat_q;
    logic [4:0]  memRd_q;
    logic        excp_q;
    logic [3:0]  excpCode_q;
    logic [31:0] excpAddr_q;

    logic [1:0]  size_d;
    logic        misaligned_d;
    logic [3:0]  sel_d;
    logic [31:0] wdat_d;
    logic [31:0] shifted_d;
    logic [31:0] loadData_d;

    // Decode the incoming request: size, alignment, byte lanes and replicated store data.
    always_comb begin
        size_d       = SIZE_WORD;
        misaligned_d = 1'b0;
        sel_d        = 4'b1111;
        wdat_d       = wdata_i;
        case (funct3_i[1:0])
            2'b00:   size_d = SIZE_BYTE;
            2'b01:   size_d = SIZE_HALF;
            default: size_d = SIZE_WORD;
        endcase
        case (size_d)
            SIZE_BYTE: begin
                sel_d  = 4'b0001 << addr_i[1:0];
                wdat_d = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                misaligned_d = addr_i[0];
                sel_d        = 4'b0011 << {addr_i[1], 1'b0};
                wdat_d       = {2{wdata_i[15:0]}};
            end
            default: begin
                misaligned_d = (addr_i[1:0] != 2'b00);
                sel_d        = 4'b1111;
                wdat_d       = wdata_i;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    always_comb begin
        shifted_d  = wbm_dat_i >> {lane_q, 3'b000};
        loadData_d = shifted_d;
        case (size_q)
            SIZE_BYTE: loadData_d = {{24{~unsigned_q & shifted_d[7]}}, shifted_d[7:0]};
            SIZE_HALF: loadData_d = {{16{~unsigned_q & shifted_d[15]}}, shifted_d[15:0]};
            default:   loadData_d = shifted_d;
        endcase
    end

    // Access sequencer: issues the bus cycle and produces the registered result pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            rd_q       <= '0;
            store_q    <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            sel_q      <= '0;
            wdat_q     <= '0;
            memAck_q   <= 1'b0;
            memDat_q   <= '0;
            memRd_q    <= '0;
            excp_q     <= 1'b0;
            excpCode_q <= '0;
            excpAddr_q <= '0;
        end else begin
            memAck_q   <= 1'b0;
            memDat_q   <= '0;
            memRd_q    <= '0;
            excp_q     <= 1'b0;
            excpCode_q <= '0;
            excpAddr_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        if (misaligned_d) begin
                            state_q    <= EXC;
                            excp_q     <= 1'b1;
                            excpCode_q <= we_i ? CODE_STORE_MISALIGN : CODE_LOAD_MISALIGN;
                            excpAddr_q <= addr_i;
                        end else begin
                            state_q    <= BUS;
                            cnt_q      <= '0;
                            cyc_q      <= 1'b1;
                            stb_q      <= 1'b1;
                            we_q       <= we_i;
                            adr_q      <= {addr_i[31:2], 2'b00};
                            sel_q      <= sel_d;
                            wdat_q     <= wdat_d;
                            lane_q     <= addr_i[1:0];
                            size_q     <= size_d;
                            unsigned_q <= funct3_i[2];
                            rd_q       <= rd_i;
                            store_q    <= we_i;
                        end
                    end
                end
                BUS: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (wbm_err_i) begin
                        state_q    <= EXC;
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        excp_q     <= 1'b1;
                        excpCode_q <= store_q ? CODE_STORE_FAULT : CODE_LOAD_FAULT;
                        excpAddr_q <= {adr_q[31:2], lane_q};
                    end else if (wbm_ack_i) begin
                        state_q  <= DONE;
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        memAck_q <= 1'b1;
                        memDat_q <= store_q ? 32'd0 : loadData_d;
                        memRd_q  <= store_q ? 5'd0 : rd_q;
                    end else if (cnt_q == LAST_CNT) begin
                        state_q    <= EXC;
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        excp_q     <= 1'b1;
                        excpCode_q <= store_q ? CODE_STORE_FAULT : CODE_LOAD_FAULT;
                        excpAddr_q <= {adr_q[31:2], lane_q};
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                EXC: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall while a request waits to be issued or a bus cycle is in flight.
    always_comb begin
        stall_o = ((state_q == IDLE) && req_i) || (state_q == BUS);
    end

    assign mem_ack_o   = memAck_q;
    assign mem_dat_o   = memDat_q;
    assign mem_rd_o    = memRd_q;
    assign excp_o      = excp_q;
    assign excp_code_o = excpCode_q;
    assign excp_addr_o = excpAddr_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = wdat_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_we_o    = we_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;

endmodule
